pixel_sensor_ctrl: RTL and testbench
====================================

Name: pixel_sensor_ctrl

Overview:
- Frame-sequencing controller that sits directly upstream of the 2x2 pixel array.
- Generates the erase/expose/convert/read12/read34 phase strobes and drives the 8-bit digital ADC ramp onto the pixel data buses during convert.
- Captures the pixel codes that the array returns during the read phases and presents them to downstream logic with a valid strobe.

Parameters:
- ERASE_CYCLES, 5: clock cycles erase is held high.
- READ_CYCLES, 5: clock cycles each of read12/read34 is held high.
- RAMP_W, 8: ramp/pixel code width; convert lasts 2**RAMP_W cycles.
- EXP_W, 16: width of exposure-length input.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin one frame; sampled only in IDLE
- continuous  in  1  re-launch a frame immediately after frame_done
- exp_cycles  in  EXP_W  exposure length in cycles; latched on frame launch
- erase  out  1  pixel erase strobe
- expose  out  1  pixel expose strobe
- convert  out  1  convert strobe; array compares against ramp
- read12  out  1  array drives pixData1/2
- read34  out  1  array drives pixData3/4
- ramp_data  out  RAMP_W  digital ramp, driven to all four buses when the matching read is low
- pix_in12  in  2*RAMP_W  {pixData2,pixData1}
- pix_in34  in  2*RAMP_W  {pixData4,pixData3}
- pix_out  out  2*RAMP_W  captured pixel pair
- pix_valid  out  1  one-cycle pulse, pix_out valid
- pix_sel  out  1  0 = pair 1/2, 1 = pair 3/4
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse at end of READ34

Behaviour:
- Reset state: all outputs 0; state IDLE; latched exposure length 0.
- States: IDLE, ERASE, EXPOSE, SETTLE, CONVERT, READ12, READ34.
- All outputs are registered Moore decodes of state. At most one of erase/expose/convert/read12/read34 is high in any cycle.
- IDLE: start=1 latches exp_cycles (a value of 0 is treated as 1) and moves to ERASE on the next edge. busy goes high in the same cycle erase rises.
- ERASE: ERASE_CYCLES cycles -> EXPOSE.
- EXPOSE: latched exposure length in cycles -> SETTLE.
- SETTLE: exactly 1 cycle, all strobes low -> CONVERT.
- CONVERT: 2**RAMP_W cycles.
  - ramp_data = 0 in the first cycle and increments by 1 each cycle, reaching 255 in the last cycle.
  - ramp_data returns to 0 on exit and is held at 0 outside CONVERT; no wrap is ever visible.
  - Exit -> READ12.
- READ12: READ_CYCLES cycles.
  - pix_in12 is sampled on the last cycle.
  - Next cycle: pix_valid=1, pix_sel=0, pix_out holds the sample.
  - Exit -> READ34.
- READ34: same as READ12, with pix_sel=1 and sampling pix_in34.
  - On exit, frame_done pulses for 1 cycle, coincident with the pix_valid of pair 3/4.
  - Next state: ERASE if continuous=1 or start=1, otherwise IDLE.
  - A re-launch re-latches exp_cycles.
- pix_out holds its value until the next capture.
- start is ignored while busy. A change of exp_cycles mid-frame has no effect.
- Frame length = ERASE_CYCLES + Texp + 1 + 256 + 2*READ_CYCLES cycles.
- Asynchronous reset mid-frame: all strobes drop immediately, state goes to IDLE, no pix_valid or frame_done is emitted.
- Phase timing uses a single down-counter reloaded on every state entry.

Optional Feature:
- Macro PIXEL_SENSOR_CTRL_ABORT_EN.
- Defined:
  - Adds input abort (1) and output aborted (1).
  - abort=1 in any non-IDLE state forces IDLE on the next edge, with all strobes and ramp_data at 0.
  - Suppresses any pending pix_valid and frame_done; aborted pulses for 1 cycle.
  - abort in IDLE is ignored. abort has priority over start and continuous.
- Undefined: the ports do not exist and a frame always runs to completion.

Decomposition:
- Package pixel_sensor_ctrl_pkg holds:
  - the state enum (state_t);
  - the RAMP_STEPS constant (2**RAMP_W);
  - the default cycle constants.
- One sub-module, phase_timer: loadable down-counter with load, value, and a zero/last flag. It is shared for all phase durations.

Test Plan:
- Single frame, exp_cycles=255, start for 1 cycle -> erase high 5 cycles, expose 255, 1 gap, convert 256, read12 5, read34 5; frame_done 527 cycles after erase rises; busy then low.
- Ramp check -> ramp_data sequence 0,1,...,255 during convert with no skips or repeats, 0 at all other times; strobes are mutually exclusive throughout.
- Model array returns pix_in12=16'h3A7F, pix_in34=16'h0102 -> pix_valid pulse with pix_sel=0 and pix_out=3A7F, then pix_sel=1 and pix_out=0102 coincident with frame_done.
- continuous=1 and exp_cycles=0 -> expose lasts 1 cycle; erase rises the cycle after frame_done; back-to-back frames of 273 cycles each.
- Reset asserted mid-CONVERT at ramp=100 -> all outputs 0 immediately, no pix_valid or frame_done; a fresh start gives a normal frame.
- With ABORT_EN, abort during EXPOSE -> IDLE next edge, aborted pulses once, no frame_done; start during busy is ignored.

Source files
------------

// File: rtl/pixel_sensor_ctrl_pkg.sv
// Shared types and default timing constants for the 2x2 pixel-array frame sequencer.
package pixel_sensor_ctrl_pkg;

    localparam int DEF_ERASE_CYCLES = 5;
    localparam int DEF_READ_CYCLES  = 5;
    localparam int DEF_RAMP_W       = 8;
    localparam int DEF_EXP_W        = 16;

    function automatic int ramp_steps(input int w);
        return 1 << w;
    endfunction

    localparam int RAMP_STEPS = ramp_steps(DEF_RAMP_W);

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        SETTLE,
        CONVERT,
        READ12,
        READ34
    } state_t;

endpackage

// File: rtl/pixel_sensor_ctrl_if.sv
// Host/array-facing signal bundle of pixel_sensor_ctrl.
// abort/aborted exist only when PIXEL_SENSOR_CTRL_ABORT_EN is defined.
interface pixel_sensor_ctrl_if
    import pixel_sensor_ctrl_pkg::*;
#(
    parameter int RAMP_W = DEF_RAMP_W,
    parameter int EXP_W  = DEF_EXP_W
) ();

    logic                  start;
    logic                  continuous;
    logic [EXP_W-1:0]      exp_cycles;
    logic                  erase;
    logic                  expose;
    logic                  convert;
    logic                  read12;
    logic                  read34;
    logic [RAMP_W-1:0]     ramp_data;
    logic [2*RAMP_W-1:0]   pix_in12;
    logic [2*RAMP_W-1:0]   pix_in34;
    logic [2*RAMP_W-1:0]   pix_out;
    logic                  pix_valid;
    logic                  pix_sel;
    logic                  busy;
    logic                  frame_done;
`ifdef PIXEL_SENSOR_CTRL_ABORT_EN
    logic                  abort;
    logic                  aborted;
`endif

    // Host and pixel-array side.
    modport master (
        output start, continuous, exp_cycles, pix_in12, pix_in34,
        input  erase, expose, convert, read12, read34, ramp_data,
        input  pix_out, pix_valid, pix_sel, busy, frame_done
`ifdef PIXEL_SENSOR_CTRL_ABORT_EN
        , output abort, input aborted
`endif
    );

    // Sequencer side.
    modport slave (
        input  start, continuous, exp_cycles, pix_in12, pix_in34,
        output erase, expose, convert, read12, read34, ramp_data,
        output pix_out, pix_valid, pix_sel, busy, frame_done
`ifdef PIXEL_SENSOR_CTRL_ABORT_EN
        , input abort, output aborted
`endif
    );

endinterface

// File: rtl/pixel_sensor_ctrl_phase_timer.sv
// Loadable down-counter shared by every phase; last is high while the count is zero.
module phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         last
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= value;
        else if (count != '0)
            count <= count - W'(1);
    end

    assign last = (count == '0);

endmodule

// File: rtl/pixel_sensor_ctrl.sv
// Frame sequencer for the 2x2 pixel array: phase strobes, ADC ramp and pixel capture.
// Optional abort input/aborted output under PIXEL_SENSOR_CTRL_ABORT_EN.
module pixel_sensor_ctrl
    import pixel_sensor_ctrl_pkg::*;
#(
    parameter int ERASE_CYCLES = DEF_ERASE_CYCLES,
    parameter int READ_CYCLES  = DEF_READ_CYCLES,
    parameter int RAMP_W       = DEF_RAMP_W,
    parameter int EXP_W        = DEF_EXP_W
) (
    input logic                clk,
    input logic                reset,
    pixel_sensor_ctrl_if.slave bus
);

    localparam int STEPS = ramp_steps(RAMP_W);
    localparam int TW    = (EXP_W > RAMP_W + 1) ? EXP_W : RAMP_W + 1;

    state_t           state, next_state;
    logic [EXP_W-1:0] exp_len;
    logic             launch, abort_now, capture, last, load;
    logic [TW-1:0]    load_value;

`ifdef PIXEL_SENSOR_CTRL_ABORT_EN
    assign abort_now = bus.abort && (state != IDLE);
`else
    assign abort_now = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state; // NOTE: sequential state uses <= so every flop samples pre-edge values
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch)
        next_state = state;
        launch     = 1'b0;
        if (abort_now) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (bus.start) begin next_state = ERASE; launch = 1'b1; end
                ERASE:   if (last) next_state = EXPOSE;
                EXPOSE:  if (last) next_state = SETTLE;
                SETTLE:  if (last) next_state = CONVERT;
                CONVERT: if (last) next_state = READ12;
                READ12:  if (last) next_state = READ34;
                READ34:
                    if (last) begin
                        if (bus.continuous || bus.start) begin
                            next_state = ERASE;
                            launch     = 1'b1;
                        end else begin
                            next_state = IDLE;
                        end
                    end
                default: next_state = IDLE;
            endcase
        end
    end

    // The timer is reloaded with (duration - 1) on every state change.
    always_comb begin
        load_value = '0;
        unique case (next_state)
            ERASE:          load_value = TW'(ERASE_CYCLES - 1);
            EXPOSE:         load_value = TW'(exp_len) - TW'(1);
            CONVERT:        load_value = TW'(STEPS - 1);
            READ12, READ34: load_value = TW'(READ_CYCLES - 1);
            default:        load_value = '0;
        endcase
    end

    assign load    = (next_state != state);
    assign capture = ((state == READ12) || (state == READ34)) && last && !abort_now;

    phase_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .value (load_value),
        .last  (last)
    );

    // Outputs decode next_state so each strobe lines up with the state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_len        <= '0;
            bus.erase      <= 1'b0;
            bus.expose     <= 1'b0;
            bus.convert    <= 1'b0;
            bus.read12     <= 1'b0;
            bus.read34     <= 1'b0;
            bus.busy       <= 1'b0;
            bus.ramp_data  <= '0;
            bus.pix_valid  <= 1'b0;
            bus.pix_sel    <= 1'b0;
            bus.pix_out    <= '0;
            bus.frame_done <= 1'b0;
`ifdef PIXEL_SENSOR_CTRL_ABORT_EN
            bus.aborted    <= 1'b0;
`endif
        end else begin
            if (launch)
                exp_len <= (bus.exp_cycles == '0) ? EXP_W'(1) : bus.exp_cycles;
            bus.erase      <= (next_state == ERASE);
            bus.expose     <= (next_state == EXPOSE);
            bus.convert    <= (next_state == CONVERT);
            bus.read12     <= (next_state == READ12);
            bus.read34     <= (next_state == READ34);
            bus.busy       <= (next_state != IDLE);
            bus.ramp_data  <= (state == CONVERT && next_state == CONVERT)
                              ? bus.ramp_data + RAMP_W'(1) : '0;
            bus.pix_valid  <= capture;
            bus.frame_done <= capture && (state == READ34);
            if (capture) begin
                bus.pix_out <= (state == READ34) ? bus.pix_in34 : bus.pix_in12;
                bus.pix_sel <= (state == READ34);
            end
`ifdef PIXEL_SENSOR_CTRL_ABORT_EN
            bus.aborted    <= abort_now;
`endif
        end
    end

endmodule

// File: tb/tb_pixel_sensor_ctrl.sv
// Self-checking bench for pixel_sensor_ctrl: a per-frame schedule of expected phases
// is built from the phase durations and compared against the DUT every cycle.
module tb_pixel_sensor_ctrl;
    import pixel_sensor_ctrl_pkg::*;

    localparam int ERASE_N = DEF_ERASE_CYCLES;
    localparam int READ_N  = DEF_READ_CYCLES;
    localparam int PIX_W   = 2 * DEF_RAMP_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pixel_sensor_ctrl_if bus ();

    pixel_sensor_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int {PH_IDLE, PH_ERASE, PH_EXPOSE, PH_SETTLE, PH_CONVERT, PH_READ12, PH_READ34} phase_e;
    typedef struct {
        phase_e phase;
        int     ramp;
        bit     last;
    } slot_t;

    slot_t sched[$];

    int total = 0;
    int bad   = 0;

    bit             exp_valid = 0, exp_done = 0, exp_abort = 0, exp_sel = 0;
    logic [PIX_W-1:0] exp_out = '0;

    bit in_start = 0, in_cont = 0, in_abort = 0, fixed_pix = 1;
    int in_exp = 0;

    int cyc = 0, last_rise = -1, done_gap = -1, rise_gap = -1;
    bit prev_erase = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic void add_slots(input phase_e ph, input int n, input bit ramp_up);
        for (int i = 0; i < n; i++) begin
            slot_t s;
            s.phase = ph;
            s.ramp  = ramp_up ? i : 0;
            s.last  = (ph == PH_READ12 || ph == PH_READ34) && (i == n - 1);
            sched.push_back(s);
        end
    endfunction

    function automatic void push_frame(input int texp_raw);
        int texp = (texp_raw == 0) ? 1 : texp_raw;
        add_slots(PH_ERASE,   ERASE_N,    0);
        add_slots(PH_EXPOSE,  texp,       0);
        add_slots(PH_SETTLE,  1,          0);
        add_slots(PH_CONVERT, RAMP_STEPS, 1);
        add_slots(PH_READ12,  READ_N,     0);
        add_slots(PH_READ34,  READ_N,     0);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_strobes"}, {bus.erase, bus.expose, bus.convert, bus.read12, bus.read34}, 0);
        check({tag, "_ramp"}, bus.ramp_data, 0);
        check({tag, "_flags"}, {bus.busy, bus.pix_valid, bus.pix_sel, bus.frame_done}, 0);
        check({tag, "_pix_out"}, bus.pix_out, 0);
    endtask

    // One clock cycle: compare the current cycle, then drive inputs and advance the model.
    task automatic step();
        slot_t cur;
        bit was_idle, abort_hit;
        logic [4:0] strobes, want;
        logic [PIX_W-1:0] p12, p34;
        @(negedge clk);
        cyc++;
        was_idle = (sched.size() == 0);
        if (was_idle) begin
            cur.phase = PH_IDLE;
            cur.ramp  = 0;
            cur.last  = 0;
        end else begin
            cur = sched[0];
        end
        strobes = {bus.erase, bus.expose, bus.convert, bus.read12, bus.read34};
        want    = {cur.phase == PH_ERASE, cur.phase == PH_EXPOSE, cur.phase == PH_CONVERT,
                   cur.phase == PH_READ12, cur.phase == PH_READ34};
        check("strobes", strobes, want);
        check("exclusive", $countones(strobes) <= 1, 1);
        check("ramp", bus.ramp_data, cur.ramp);
        check("busy", bus.busy, !was_idle);
        check("pix_valid", bus.pix_valid, exp_valid);
        check("pix_sel", bus.pix_sel, exp_sel);
        check("pix_out", bus.pix_out, exp_out);
        check("frame_done", bus.frame_done, exp_done);
`ifdef PIXEL_SENSOR_CTRL_ABORT_EN
        check("aborted", bus.aborted, exp_abort);
`endif
        if (bus.frame_done) done_gap = (last_rise >= 0) ? cyc - last_rise : -2;
        if (bus.erase && !prev_erase) begin
            if (last_rise >= 0) rise_gap = cyc - last_rise;
            last_rise = cyc;
        end
        prev_erase = bus.erase;

        p12 = fixed_pix ? 16'h3A7F : PIX_W'($urandom);
        p34 = fixed_pix ? 16'h0102 : PIX_W'($urandom);
        bus.start      = in_start;
        bus.continuous = in_cont;
        bus.exp_cycles = in_exp[15:0];
        bus.pix_in12   = p12;
        bus.pix_in34   = p34;
        abort_hit      = 0;
`ifdef PIXEL_SENSOR_CTRL_ABORT_EN
        bus.abort = in_abort;
        abort_hit = in_abort && !was_idle;
`endif
        exp_valid = 0;
        exp_done  = 0;
        exp_abort = 0;
        if (abort_hit) begin
            sched.delete();
            exp_abort = 1;
        end else begin
            if (cur.last) begin
                exp_valid = 1;
                exp_sel   = (cur.phase == PH_READ34);
                exp_out   = exp_sel ? p34 : p12;
                exp_done  = exp_sel;
            end
            if (!was_idle) void'(sched.pop_front());
            if (sched.size() == 0 && (was_idle ? in_start : (in_start || in_cont)))
                push_frame(in_exp);
        end
        in_start = 0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.continuous = 1'b0;
        bus.exp_cycles = '0;
        bus.pix_in12   = '0;
        bus.pix_in34   = '0;
`ifdef PIXEL_SENSOR_CTRL_ABORT_EN
        bus.abort      = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Single frame, exposure 255, fixed pixel codes from the array.
        in_exp = 255; in_start = 1; last_rise = -1; done_gap = -1;
        repeat (540) step();
        check("frame_len_255", done_gap, ERASE_N + 255 + 1 + RAMP_STEPS + 2 * READ_N);
        check("idle_after_frame", bus.busy, 0);

        // Random starts (ignored while busy), random exposures and pixel codes.
        fixed_pix = 0;
        for (int i = 0; i < 900; i++) begin
            in_exp   = $urandom_range(0, 40);
            in_start = ($urandom_range(0, 7) == 0);
            step();
        end
        repeat (400) step();

        // Back-to-back frames, exposure 0 treated as 1.
        in_exp = 0; in_cont = 1; in_start = 1;
        last_rise = -1; rise_gap = -1; done_gap = -1;
        repeat (2 * 273 + 10) step();
        check("cont_erase_gap", rise_gap, 273);
        check("cont_frame_done", done_gap, 273);
        in_cont = 0;
        repeat (300) step();

        // Asynchronous reset in the middle of CONVERT at ramp 100.
        in_exp = 10; in_start = 1;
        step();
        for (int i = 0; i < 400 && !(sched.size() > 0 && sched[0].phase == PH_CONVERT && sched[0].ramp == 100); i++)
            step();
        @(posedge clk);
        #1;
        check("ramp_before_reset", bus.ramp_data, 100);
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        sched.delete();
        exp_valid = 0; exp_done = 0; exp_abort = 0; exp_sel = 0; exp_out = '0;
        @(negedge clk);
        reset = 1'b0;

        // Fresh frame after reset.
        e = $urandom_range(1, 30);
        in_exp = e; in_start = 1; last_rise = -1; done_gap = -1;
        repeat (350) step();
        check("frame_len_after_reset", done_gap, ERASE_N + e + 1 + RAMP_STEPS + 2 * READ_N);

`ifdef PIXEL_SENSOR_CTRL_ABORT_EN
        // Abort during EXPOSE with start also high; then abort while idle.
        in_exp = 50; in_start = 1;
        step();
        for (int i = 0; i < 50 && !(sched.size() > 0 && sched[0].phase == PH_EXPOSE); i++)
            step();
        repeat (10) step();
        in_abort = 1; in_start = 1;
        step();
        in_abort = 0;
        repeat (20) step();
        check("idle_after_abort", bus.busy, 0);
        in_abort = 1;
        step();
        in_abort = 0;
        repeat (5) step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
